// File: rtl/dmem_responder.sv
// M-stage data-memory responder: one request in flight, fixed latency,
// byte-enabled word RAM with misalignment and range error reporting.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_m,
  input  logic        req_write_m,
  input  logic [31:0] req_addr_m,
  input  logic [31:0] req_wdata_m,
  input  logic [3:0]  req_be_m,
  output logic        req_ready_m,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall_m
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } hold_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  hold_t         hold_q, hold_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          bad;
  logic          do_wr;
  logic [31:0]   rword;
  logic [31:0]   lane_mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_m) begin
          hold_d = '{
            wr:    req_write_m,
            addr:  req_addr_m,
            wdata: req_wdata_m,
            be:    req_be_m
          };
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Upper address bits only feed the range check, never the index.
  always_comb begin
    idx       = hold_q.addr[AW+1:2];
    bad       = (hold_q.addr[1:0] != 2'b00) ||
                (hold_q.addr >= LIMIT);
    rword     = mem[idx];
    lane_mask = {{8{hold_q.be[3]}}, {8{hold_q.be[2]}},
                 {8{hold_q.be[1]}}, {8{hold_q.be[0]}}};
    req_ready_m = (state_q == IDLE);
    rsp_valid   = (state_q == RESP);
    stall_m     = ((state_q == IDLE) && req_valid_m) ||
                  (state_q == BUSY);
    rsp_err     = rsp_valid && bad;
    do_wr       = rsp_valid && hold_q.wr && !bad;
    rsp_rdata   = '0;
    if (rsp_valid && !bad && !hold_q.wr) begin
      rsp_rdata = rword & lane_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (hold_q.be[i]) begin
          mem[idx][8*i +: 8] <= hold_q.wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: timing/data model checked every cycle,
// directed scenarios with literal expectations, randomized traffic.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk;
  logic        reset;
  logic        req_valid_m;
  logic        req_write_m;
  logic [31:0] req_addr_m;
  logic [31:0] req_wdata_m;
  logic [3:0]  req_be_m;
  logic        req_ready_m;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall_m;

  logic        b_valid;
  logic        b_write;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_be;
  logic        b_ready;
  logic        b_rv;
  logic [31:0] b_rdata;
  logic        b_err;
  logic        b_stall;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid_m(req_valid_m), .req_write_m(req_write_m),
    .req_addr_m(req_addr_m), .req_wdata_m(req_wdata_m),
    .req_be_m(req_be_m), .req_ready_m(req_ready_m),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .stall_m(stall_m)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid_m(b_valid), .req_write_m(b_write),
    .req_addr_m(b_addr), .req_wdata_m(b_wdata),
    .req_be_m(b_be), .req_ready_m(b_ready),
    .rsp_valid(b_rv), .rsp_rdata(b_rdata),
    .rsp_err(b_err), .stall_m(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a request accepted in cycle T answers in cycle T+LAT.
  logic [31:0] mem_m [DEPTH];
  bit          known [DEPTH][4];
  bit          has_pend = 0;
  int          rsp_cyc  = 0;
  int          cyc      = 0;
  bit          p_w;
  logic [31:0] p_a;
  logic [31:0] p_wd;
  logic [3:0]  p_be;

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  always @(negedge reset) has_pend = 0;

  always @(posedge clk) begin
    if (!reset) begin
      has_pend = 0;
    end else if (has_pend) begin
      if (cyc == rsp_cyc) begin
        if (p_w && !is_bad(p_a)) begin
          for (int i = 0; i < 4; i++) begin
            if (p_be[i]) begin
              mem_m[p_a / 4][8*i +: 8] = p_wd[8*i +: 8];
              known[p_a / 4][i] = 1;
            end
          end
        end
        has_pend = 0;
      end
    end else if (req_valid_m) begin
      has_pend = 1;
      rsp_cyc  = cyc + LAT;
      p_w  = req_write_m;
      p_a  = req_addr_m;
      p_wd = req_wdata_m;
      p_be = req_be_m;
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    bit          idle;
    bit          inr;
    bit          e_stall;
    logic [31:0] e_rd;
    logic [31:0] m;
    idle    = !has_pend;
    inr     = has_pend && (cyc == rsp_cyc);
    e_stall = (idle && req_valid_m) || (has_pend && cyc < rsp_cyc);
    chk("ready", 32'(req_ready_m), 32'(idle));
    chk("rsp_valid", 32'(rsp_valid), 32'(inr));
    chk("stall", 32'(stall_m), 32'(e_stall));
    if (inr || !reset) begin
      e_rd = '0;
      m    = '1;
      if (inr && !p_w && !is_bad(p_a)) begin
        for (int i = 0; i < 4; i++) begin
          if (p_be[i]) begin
            e_rd[8*i +: 8] = mem_m[p_a / 4][8*i +: 8];
            if (!known[p_a / 4][i]) m[8*i +: 8] = 8'h00;
          end
        end
      end
      chk("rsp_err", 32'(rsp_err), 32'(inr && is_bad(p_a)));
      chk("rsp_rdata", rsp_rdata & m, e_rd & m);
    end
  end

  task automatic do_req(input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output bit er,
                        output int lat, output bit s0, output bit s1);
    bit got;
    int t0;
    rd = '0; er = 0; lat = -1; s0 = 0; s1 = 0; t0 = 0;
    @(posedge clk); #1;
    req_valid_m = 1; req_write_m = w; req_addr_m = a;
    req_wdata_m = wd; req_be_m = be;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (req_ready_m) begin
        got = 1; s0 = stall_m; t0 = cyc;
      end
    end
    chk("accept_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid_m = 0;
    req_write_m = 1'($urandom);
    req_addr_m  = $urandom;
    req_wdata_m = $urandom;
    req_be_m    = 4'($urandom);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (i == 0) s1 = stall_m;
      if (rsp_valid) begin
        got = 1; rd = rsp_rdata; er = rsp_err; lat = cyc - t0;
      end
    end
    chk("response_seen", 32'(got), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    bit          er;
    bit          s0, s1;
    int          lat;
    int          cnt;
    logic [5:0]  rvv, stv;
    logic [31:0] rdv [6];
    bit          rdy [6];
    int          r;
    logic [31:0] a;

    reset = 0;
    req_valid_m = 0; req_write_m = 0; req_addr_m = 0;
    req_wdata_m = 0; req_be_m = 0;
    b_valid = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_be = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;

    for (int i = 0; i < 16; i++)
      do_req(1, 32'(i * 4), {8'hA5, 8'(i), 8'h5A, 8'(i)}, 4'hF,
             rd, er, lat, s0, s1);

    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, s0, s1);
    chk("st_stall_t0", 32'(s0), 32'd1);
    chk("st_stall_t1", 32'(s1), 32'd1);
    chk("st_latency", 32'(lat), 32'd2);
    chk("st_err", 32'(er), 32'd0);
    do_req(0, 32'h10, 32'h0, 4'hF, rd, er, lat, s0, s1);
    chk("ld_deadbeef", rd, 32'hDEADBEEF);
    chk("ld_latency", 32'(lat), 32'd2);

    do_req(1, 32'h20, 32'h0, 4'hF, rd, er, lat, s0, s1);
    do_req(1, 32'h20, 32'h11223344, 4'b0101, rd, er, lat, s0, s1);
    do_req(0, 32'h20, 32'h0, 4'hF, rd, er, lat, s0, s1);
    chk("lanes_full", rd, 32'h00220044);
    do_req(0, 32'h20, 32'h0, 4'b0001, rd, er, lat, s0, s1);
    chk("lanes_b0", rd, 32'h00000044);

    do_req(0, 32'h22, 32'h0, 4'hF, rd, er, lat, s0, s1);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_rdata", rd, 32'h0);
    do_req(1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, rd, er, lat, s0, s1);
    chk("range_err", 32'(er), 32'd1);
    chk("range_rdata", rd, 32'h0);
    do_req(0, 32'h0, 32'h0, 4'hF, rd, er, lat, s0, s1);
    chk("word0_intact", rd, 32'hA5005A00);

    // Hold valid through BUSY while the address moves.
    @(posedge clk); #1;
    req_valid_m = 1; req_write_m = 0; req_addr_m = 32'h10; req_be_m = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rdy[k] = req_ready_m;
      rvv[k] = rsp_valid;
      rdv[k] = rsp_rdata;
      if (k == 0) begin
        @(posedge clk); #1;
        req_addr_m = 32'h20;
      end
    end
    @(posedge clk); #1;
    req_valid_m = 0;
    chk("hold_ready", 32'({rdy[5], rdy[4], rdy[3], rdy[2], rdy[1], rdy[0]}),
        32'b001001);
    chk("hold_rsp", 32'(rvv), 32'b100100);
    chk("hold_rdata1", rdv[2], 32'hDEADBEEF);
    chk("hold_rdata2", rdv[5], 32'h00220044);

    @(posedge clk); #1;
    req_valid_m = 1; req_write_m = 1; req_addr_m = 32'h30;
    req_wdata_m = 32'h55AA55AA; req_be_m = 4'hF;
    @(negedge clk);
    chk("rst_accept", 32'(req_ready_m), 32'd1);
    @(posedge clk); #1;
    req_valid_m = 0;
    reset = 0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready_m), 32'd1);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_stall", 32'(stall_m), 32'd0);
    @(posedge clk); #1;
    reset = 1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("rst_no_rsp", 32'(cnt), 32'd0);
    do_req(0, 32'h30, 32'h0, 4'hF, rd, er, lat, s0, s1);
    chk("rst_old_value", rd, 32'hA50C5A0C);

    @(posedge clk); #1;
    b_valid = 1; b_write = 1; b_addr = 32'h0;
    b_wdata = 32'hCAFEF00D; b_be = 4'hF;
    @(negedge clk);
    chk("l1_accept", 32'(b_ready), 32'd1);
    @(posedge clk); #1;
    b_valid = 0;
    @(negedge clk);
    chk("l1_st_rsp", 32'(b_rv), 32'd1);
    @(posedge clk); #1;
    b_valid = 1; b_write = 0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rvv[k] = b_rv;
      stv[k] = b_stall;
      rdv[k] = b_rdata;
      if (b_rv && b_stall) cnt++;
    end
    @(posedge clk); #1;
    b_valid = 0;
    chk("l1_rsp_pattern", 32'(rvv), 32'b101010);
    chk("l1_stall_pattern", 32'(stv), 32'b010101);
    chk("l1_stall_in_resp", 32'(cnt), 32'd0);
    chk("l1_rdata1", rdv[1], 32'hCAFEF00D);
    chk("l1_rdata5", rdv[5], 32'hCAFEF00D);

    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 63) != 0);
      r = $urandom_range(0, 9);
      if (r <= 6)      a = 32'($urandom_range(0, 15)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) |
                           32'($urandom_range(1, 3));
      else if (r == 8) a = 32'(DEPTH * 4) +
                           (32'($urandom_range(0, 255)) << 2);
      else             a = $urandom;
      req_valid_m = 1'($urandom);
      req_write_m = 1'($urandom);
      req_addr_m  = a;
      req_wdata_m = $urandom;
      req_be_m    = 4'($urandom);
    end
    @(posedge clk); #1;
    reset = 1;
    req_valid_m = 0;
    repeat (6) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
